decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set register, immediate and writeback data width.
REQ-002 Parameter ADDRESS_WIDTH, default 32, SHALL set PC width.
REQ-003 Parameter REG_COUNT, default 32, SHALL set the number of architectural registers; REG_AW = clog2(REG_COUNT).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high. Ports:
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 valid_f, instr_f, pc_f, pc_plus4_f  in  1/DATA_WIDTH/ADDRESS_WIDTH/ADDRESS_WIDTH  fetched instruction and its PCs.
REQ-008 stall_d, flush_d  in  1/1  external hold and kill of the D->E register.
REQ-009 reg_write_w, rd_w, result_w  in  1/REG_AW/DATA_WIDTH  writeback port.
REQ-010 hazard_stall  out  1  combinational load-use stall request to fetch.
REQ-011 valid_e, illegal_e  out  1/1  E-stage valid; E-stage holds an undecodable opcode.
REQ-012 ctrl_e  out  16  registered control bundle {reg_write, res_src[1:0], mem_write, jump, branch, alu_control[3:0], funct3[2:0], alu_src_a, alu_src_b, adder_src}.
REQ-013 rd1_e, rd2_e, imm_e  out  DATA_WIDTH  registered operands and immediate.
REQ-014 pc_e, pc_plus4_e  out  ADDRESS_WIDTH  registered PCs.
REQ-015 rs1_e, rs2_e, rd_e  out  REG_AW  registered register indices.

Function
REQ-016 Decode (control, immediate, register read) SHALL be combinational on instr_f; all E outputs SHALL be registered, latency 1 cycle.
REQ-017 Register file SHALL write result_w to rd_w on the rising edge when reg_write_w=1 and rd_w!=0; register 0 SHALL always read 0.
REQ-018 Read SHALL bypass same-cycle writeback: if reg_write_w, rd_w!=0 and rd_w equals the read index, read data SHALL equal result_w.
REQ-019 hazard_stall SHALL be 1 when valid_f, valid_e, ctrl_e.res_src=2'b01 (load), rd_e!=0 and rd_e equals instr_f[19:15] or instr_f[24:20] (rs2 compared conservatively for all formats).
REQ-020 Register update priority per edge: flush_d -> bubble; else stall_d -> hold all E outputs; else hazard_stall -> bubble; else capture decode of instr_f with valid_e=valid_f.
REQ-021 A bubble SHALL set valid_e=0, illegal_e=0, ctrl_e=0; data fields are don't-care but SHALL be zero.
REQ-022 illegal_e SHALL be 1 for a captured valid instruction whose opcode is not in the supported set; its ctrl_e SHALL be 0.
REQ-023 A held E register (stall_d) SHALL NOT re-read operands; forwarding to E is the execute stage's responsibility.
REQ-024 valid_f=0 SHALL capture as a bubble and SHALL force hazard_stall=0.

Reset
REQ-025 While rst=1, all E outputs SHALL be 0 and all registers of the file SHALL be cleared to 0, asynchronously.
REQ-026 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; first capture occurs on the first edge after rst deasserts.

Structure
REQ-027 Package decode_pkg SHALL hold opcode constants, res_src encodings, imm-type encodings and the ctrl_e field offsets.
REQ-028 Existing control_unit and imm_ext SHALL be instantiated unchanged; the register file with bypass and reset SHALL be one sub-module, regfile_bypass.

Verification
REQ-029 Reset: rst=1 with writes pending -> all outputs 0; after release x5 reads 0.
REQ-030 Bypass: write x3=0x1234 while decoding add x4,x3,x3 same cycle -> rd1_e=rd2_e=0x1234 next cycle.
REQ-031 Load-use: lw x6,0(x1) then add x7,x6,x2 -> hazard_stall=1 one cycle, one bubble in E, add captured next cycle.
REQ-032 Priority: flush_d=1 and stall_d=1 together -> valid_e=0 next cycle; stall_d alone for 3 cycles -> E outputs unchanged.
REQ-033 x0: write rd_w=0 result 0xFFFF_FFFF, then decode reading x0 -> rd1_e=0; lw x0 followed by use of x0 -> hazard_stall=0.
REQ-034 Illegal: instr_f=0x0000_0000 valid -> illegal_e=1, ctrl_e=0; REG_COUNT=16 build passes same suite.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, result/immediate selectors, ALU ops and
// the layout of the 16-bit control bundle carried into the execute stage.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_e;

  // Bit offsets of each field inside ctrl_e (MSB first, matches ctrl_t).
  localparam int CTRL_W         = 16;
  localparam int CTRL_REG_WRITE = 15;
  localparam int CTRL_RES_SRC   = 13;
  localparam int CTRL_MEM_WRITE = 12;
  localparam int CTRL_JUMP      = 11;
  localparam int CTRL_BRANCH    = 10;
  localparam int CTRL_ALU       = 6;
  localparam int CTRL_FUNCT3    = 3;
  localparam int CTRL_SRC_A     = 2;
  localparam int CTRL_SRC_B     = 1;
  localparam int CTRL_ADDER     = 0;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] res_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_control;
    logic [2:0] funct3;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       adder_src;
  } ctrl_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Opcode decoder producing the control bundle and immediate format; any
// opcode outside the supported RV32I set yields illegal_o with zero control.
module control_unit
  import decode_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output ctrl_t      ctrl_o,
  output imm_src_e   imm_src_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    imm_src_o = IMM_NONE;
    illegal_o = 1'b0;
    case (op_i)
      OP_LOAD: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.res_src   = RES_MEM;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_I;
      end
      OP_STORE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_S;
      end
      OP_RTYPE: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_control = alu_decode(funct3_i, funct7b5_i);
      end
      OP_ITYPE: begin
        // Bit 30 is immediate data except for the shift-right pair.
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src_b   = 1'b1;
        ctrl_o.alu_control = alu_decode(funct3_i, funct7b5_i && (funct3_i == 3'b101));
        imm_src_o          = IMM_I;
      end
      OP_BRANCH: begin
        ctrl_o.branch      = 1'b1;
        ctrl_o.alu_control = ALU_SUB;
        imm_src_o          = IMM_B;
      end
      OP_JAL: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.res_src   = RES_PC4;
        ctrl_o.jump      = 1'b1;
        imm_src_o        = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.res_src   = RES_PC4;
        ctrl_o.jump      = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        ctrl_o.adder_src = 1'b1;
        imm_src_o        = IMM_I;
      end
      OP_LUI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.res_src   = RES_IMM;
        imm_src_o        = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_U;
      end
      default: illegal_o = 1'b1;
    endcase
    if (!illegal_o) ctrl_o.funct3 = funct3_i;
  end

endmodule

// File: rtl/imm_ext.sv
// Immediate extractor: assembles the sign-extended immediate for the format
// chosen by the control unit; formats without an immediate give zero.
module imm_ext
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:7]           instr_i,
  input  imm_src_e              imm_src_i,
  output logic [DATA_WIDTH-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_src_i)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'h000};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/regfile_bypass.sv
// Two-read one-write register file with x0 hard-wired to zero, asynchronous
// clear, and same-cycle write-to-read bypass.
module regfile_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_AW     = $clog2(REG_COUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [REG_AW-1:0]     wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic [REG_AW-1:0]     ra1_i,
  input  logic [REG_AW-1:0]     ra2_i,
  output logic [DATA_WIDTH-1:0] rd1_o,
  output logic [DATA_WIDTH-1:0] rd2_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // The x0 override comes last so a write aimed at x0 never bypasses.
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
    if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage and D->E pipeline register: combinational decode of instr_f,
// load-use stall detection, and a flush/stall/bubble-controlled E register.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int  DATA_WIDTH    = 32,
  parameter int  ADDRESS_WIDTH = 32,
  parameter int  REG_COUNT     = 32,
  localparam int REG_AW        = $clog2(REG_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_f,
  input  logic [DATA_WIDTH-1:0]    instr_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     reg_write_w,
  input  logic [REG_AW-1:0]        rd_w,
  input  logic [DATA_WIDTH-1:0]    result_w,
  output logic                     hazard_stall,
  output logic                     valid_e,
  output logic                     illegal_e,
  output logic [CTRL_W-1:0]        ctrl_e,
  output logic [DATA_WIDTH-1:0]    rd1_e,
  output logic [DATA_WIDTH-1:0]    rd2_e,
  output logic [DATA_WIDTH-1:0]    imm_e,
  output logic [ADDRESS_WIDTH-1:0] pc_e,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  output logic [REG_AW-1:0]        rs1_e,
  output logic [REG_AW-1:0]        rs2_e,
  output logic [REG_AW-1:0]        rd_e
);

  typedef struct packed {
    logic                     valid;
    logic                     illegal;
    ctrl_t                    ctrl;
    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;
    logic [DATA_WIDTH-1:0]    imm;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc4;
    logic [REG_AW-1:0]        rs1;
    logic [REG_AW-1:0]        rs2;
    logic [REG_AW-1:0]        rd;
  } e_reg_t;

  ctrl_t                 ctrl_f;
  imm_src_e              imm_src_f;
  logic                  illegal_f;
  logic [DATA_WIDTH-1:0] imm_f;
  logic [DATA_WIDTH-1:0] rd1_f;
  logic [DATA_WIDTH-1:0] rd2_f;
  logic [REG_AW-1:0]     rs1_f;
  logic [REG_AW-1:0]     rs2_f;
  logic [REG_AW-1:0]     rd_f;
  logic                  load_in_e;
  e_reg_t                e_q;
  e_reg_t                e_d;

  assign rs1_f = instr_f[15 +: REG_AW];
  assign rs2_f = instr_f[20 +: REG_AW];
  assign rd_f  = instr_f[7 +: REG_AW];

  control_unit u_control_unit (
    .op_i       (instr_f[6:0]),
    .funct3_i   (instr_f[14:12]),
    .funct7b5_i (instr_f[30]),
    .ctrl_o     (ctrl_f),
    .imm_src_o  (imm_src_f),
    .illegal_o  (illegal_f)
  );

  imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
    .instr_i   (instr_f[31:7]),
    .imm_src_i (imm_src_f),
    .imm_o     (imm_f)
  );

  regfile_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .REG_AW     (REG_AW)
  ) u_regfile (
    .clk_i (clk),
    .rst_i (rst),
    .we_i  (reg_write_w),
    .wa_i  (rd_w),
    .wd_i  (result_w),
    .ra1_i (rs1_f),
    .ra2_i (rs2_f),
    .rd1_o (rd1_f),
    .rd2_o (rd2_f)
  );

  // rs2 is compared for every format; a false stall only costs one cycle.
  assign load_in_e    = e_q.valid && (e_q.ctrl.res_src == RES_MEM) && (e_q.rd != '0);
  assign hazard_stall = valid_f && load_in_e &&
                        ((5'(e_q.rd) == instr_f[19:15]) || (5'(e_q.rd) == instr_f[24:20]));

  always_comb begin
    e_d = e_q;
    if (flush_d) begin
      e_d = '0;
    end else if (!stall_d) begin
      if (hazard_stall || !valid_f) begin
        e_d = '0;
      end else begin
        e_d.valid   = 1'b1;
        e_d.illegal = illegal_f;
        e_d.ctrl    = ctrl_f;
        e_d.rd1     = rd1_f;
        e_d.rd2     = rd2_f;
        e_d.imm     = imm_f;
        e_d.pc      = pc_f;
        e_d.pc4     = pc_plus4_f;
        e_d.rs1     = rs1_f;
        e_d.rs2     = rs2_f;
        e_d.rd      = rd_f;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_q <= '0;
    else     e_q <= e_d;
  end

  assign valid_e    = e_q.valid;
  assign illegal_e  = e_q.illegal;
  assign ctrl_e     = e_q.ctrl;
  assign rd1_e      = e_q.rd1;
  assign rd2_e      = e_q.rd2;
  assign imm_e      = e_q.imm;
  assign pc_e       = e_q.pc;
  assign pc_plus4_e = e_q.pc4;
  assign rs1_e      = e_q.rs1;
  assign rs2_e      = e_q.rs2;
  assign rd_e       = e_q.rd;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: an instruction-level model of the D->E register is
// checked every cycle, plus hand-computed literal checks on directed vectors.
module tb_decode_pipe;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int RCNT  = 32;
  localparam int RAW   = $clog2(RCNT);
  localparam int CLK_P = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_f;
  logic [DW-1:0]  instr_f;
  logic [AW-1:0]  pc_f, pc_plus4_f;
  logic           stall_d, flush_d;
  logic           reg_write_w;
  logic [RAW-1:0] rd_w;
  logic [DW-1:0]  result_w;
  logic           hazard_stall, valid_e, illegal_e;
  logic [15:0]    ctrl_e;
  logic [DW-1:0]  rd1_e, rd2_e, imm_e;
  logic [AW-1:0]  pc_e, pc_plus4_e;
  logic [RAW-1:0] rs1_e, rs2_e, rd_e;

  int n_checks = 0;
  int n_fail   = 0;

  decode_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .REG_COUNT(RCNT)) dut (
    .clk(clk), .rst(rst), .valid_f(valid_f), .instr_f(instr_f), .pc_f(pc_f),
    .pc_plus4_f(pc_plus4_f), .stall_d(stall_d), .flush_d(flush_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .hazard_stall(hazard_stall), .valid_e(valid_e), .illegal_e(illegal_e),
    .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
  );

  // ---------------- clock / reset ----------------
  always #(CLK_P/2) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] ctrl;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic           valid;
    logic           illegal;
    logic [15:0]    ctrl;
    logic [DW-1:0]  rd1, rd2, imm;
    logic [AW-1:0]  pc, pc4;
    logic [RAW-1:0] rs1, rs2, rd;
  } m_e_t;

  logic [DW-1:0] m_regs [RCNT];
  m_e_t          m_e;

  // Instruction semantics by mnemonic class; ALU codes: add0 sub1 and2 or3
  // xor4 slt5 sltu6 sll7 srl8 sra9. Bundle {w,res,mw,j,br,alu,f3,sa,sb,add}.
  function automatic dec_t model_decode(input logic [31:0] ins);
    dec_t        d;
    logic [3:0]  alu_tab [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    logic        w = 0, mw = 0, j = 0, br = 0, sa = 0, sb = 0, ad = 0;
    logic [1:0]  res = 0;
    logic [3:0]  alu = 0;
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] imm_u = {ins[31:12], 12'h000};
    logic [31:0] imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    d = '0;
    case (ins[6:0])
      7'h03: begin w = 1; res = 2'b01; sb = 1; d.imm = imm_i; end
      7'h23: begin mw = 1; sb = 1; d.imm = imm_s; end
      7'h33: begin
        w = 1; alu = alu_tab[f3];
        if (ins[30] && f3 == 3'd0) alu = 4'd1;
        if (ins[30] && f3 == 3'd5) alu = 4'd9;
      end
      7'h13: begin
        w = 1; sb = 1; alu = alu_tab[f3]; d.imm = imm_i;
        if (ins[30] && f3 == 3'd5) alu = 4'd9;
      end
      7'h63: begin br = 1; alu = 4'd1; d.imm = imm_b; end
      7'h6f: begin w = 1; res = 2'b10; j = 1; d.imm = imm_j; end
      7'h67: begin w = 1; res = 2'b10; j = 1; sb = 1; ad = 1; d.imm = imm_i; end
      7'h37: begin w = 1; res = 2'b11; d.imm = imm_u; end
      7'h17: begin w = 1; sa = 1; sb = 1; d.imm = imm_u; end
      default: d.illegal = 1'b1;
    endcase
    if (!d.illegal) d.ctrl = {w, res, mw, j, br, alu, f3, sa, sb, ad};
    return d;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [RAW-1:0] idx);
    if (idx == 0) return '0;
    if (reg_write_w && rd_w == idx) return result_w;
    return m_regs[idx];
  endfunction

  function automatic logic m_hazard();
    return valid_f && m_e.valid && (m_e.ctrl[14:13] == 2'b01) && (m_e.rd != 0) &&
           ((m_e.rd == instr_f[19:15]) || (m_e.rd == instr_f[24:20]));
  endfunction

  function automatic m_e_t capture_e();
    m_e_t e;
    dec_t d;
    d         = model_decode(instr_f);
    e.valid   = 1'b1;
    e.illegal = d.illegal;
    e.ctrl    = d.ctrl;
    e.imm     = d.imm;
    e.pc      = pc_f;
    e.pc4     = pc_plus4_f;
    e.rs1     = instr_f[15 +: RAW];
    e.rs2     = instr_f[20 +: RAW];
    e.rd      = instr_f[7 +: RAW];
    e.rd1     = m_read(e.rs1);
    e.rd2     = m_read(e.rs2);
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e <= '0;
      for (int i = 0; i < RCNT; i++) m_regs[i] <= '0;
    end else begin
      if (flush_d)                      m_e <= '0;
      else if (stall_d)                 m_e <= m_e;
      else if (m_hazard() || !valid_f)  m_e <= '0;
      else                              m_e <= capture_e();
      if (reg_write_w && rd_w != 0) m_regs[rd_w] <= result_w;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("hazard_stall", hazard_stall, m_hazard());
    chk("valid_e", valid_e, m_e.valid);
    chk("illegal_e", illegal_e, m_e.illegal);
    chk("ctrl_e", ctrl_e, m_e.ctrl);
    if (!m_e.illegal) begin
      chk("rd1_e", rd1_e, m_e.rd1);
      chk("rd2_e", rd2_e, m_e.rd2);
      chk("imm_e", imm_e, m_e.imm);
      chk("pc_e", pc_e, m_e.pc);
      chk("pc_plus4_e", pc_plus4_e, m_e.pc4);
      chk("rs1_e", rs1_e, m_e.rs1);
      chk("rs2_e", rs2_e, m_e.rs2);
      chk("rd_e", rd_e, m_e.rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [31:0] ins, input logic [AW-1:0] pc);
    valid_f    = v;
    instr_f    = ins;
    pc_f       = pc;
    pc_plus4_f = pc + 4;
  endtask

  task automatic wb(input logic we, input logic [RAW-1:0] rd, input logic [DW-1:0] val);
    reg_write_w = we;
    rd_w        = rd;
    result_w    = val;
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};

  initial begin
    logic [31:0] r;
    rst = 1; stall_d = 0; flush_d = 0;
    wb(1, 5, 32'h0000_ABCD);
    drive_f(1, 32'h0031_8233, 32'h100);
    repeat (2) tick();
    chk("rst_valid_e", valid_e, 0);
    chk("rst_ctrl_e", ctrl_e, 0);
    chk("rst_rd1_e", rd1_e, 0);
    chk("rst_pc_e", pc_e, 0);
    chk("rst_hazard", hazard_stall, 0);

    // Reset released: x5 was never written.
    rst = 0;
    wb(0, 0, 0);
    drive_f(1, 32'h0002_8233, 32'h104);            // add x4,x5,x0
    tick();
    chk("x5_after_rst", rd1_e, 0);
    chk("first_capture_valid", valid_e, 1);

    drive_f(0, 32'h0, 32'h0);
    wb(1, 1, 32'h100); tick();
    wb(1, 2, 32'h22);  tick();

    // Same-cycle writeback bypass.
    wb(1, 3, 32'h1234);
    drive_f(1, 32'h0031_8233, 32'h108);            // add x4,x3,x3
    tick();
    wb(0, 0, 0);
    chk("bypass_rd1", rd1_e, 32'h1234);
    chk("bypass_rd2", rd2_e, 32'h1234);
    chk("add_ctrl", ctrl_e, 16'h8000);

    // Load-use: one bubble then the consumer.
    drive_f(1, 32'h0000_A303, 32'h10C);            // lw x6,0(x1)
    tick();
    chk("lw_ctrl", ctrl_e, 16'hA012);
    drive_f(1, 32'h0023_03B3, 32'h110);            // add x7,x6,x2
    #1 chk("loaduse_hazard", hazard_stall, 1);
    tick();
    chk("loaduse_bubble_valid", valid_e, 0);
    chk("loaduse_bubble_ctrl", ctrl_e, 0);
    #1 chk("loaduse_hazard_clear", hazard_stall, 0);
    tick();
    chk("loaduse_add_valid", valid_e, 1);
    chk("loaduse_add_rs1", rs1_e, 6);
    chk("loaduse_add_rd2", rd2_e, 32'h22);
    chk("loaduse_add_pc", pc_e, 32'h110);

    // Flush beats stall.
    flush_d = 1; stall_d = 1;
    drive_f(1, 32'hFFF0_0093, 32'h114);
    tick();
    flush_d = 0; stall_d = 0;
    chk("flush_over_stall", valid_e, 0);

    // Stall holds E for 3 cycles and does not re-read a newly written x1.
    drive_f(1, 32'h0020_82B3, 32'h118);            // add x5,x1,x2
    tick();
    chk("stall_pre_rd1", rd1_e, 32'h100);
    stall_d = 1;
    wb(1, 1, 32'h999);
    drive_f(1, 32'hFFF0_0093, 32'h11C);            // addi x1,x0,-1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_rd1", rd1_e, 32'h100);
      chk("stall_hold_pc", pc_e, 32'h118);
      chk("stall_hold_ctrl", ctrl_e, 16'h8000);
    end
    stall_d = 0;
    wb(0, 0, 0);
    tick();
    chk("addi_imm", imm_e, 32'hFFFF_FFFF);
    chk("addi_ctrl", ctrl_e, 16'h8002);

    // x0 writes are dropped and never bypass; loads to x0 never stall.
    wb(1, 0, 32'hFFFF_FFFF);
    drive_f(1, 32'h0000_04B3, 32'h120);            // add x9,x0,x0
    tick();
    wb(0, 0, 0);
    chk("x0_rd1", rd1_e, 0);
    chk("x0_rd2", rd2_e, 0);
    drive_f(1, 32'h0000_A003, 32'h124);            // lw x0,0(x1)
    tick();
    drive_f(1, 32'h0000_03B3, 32'h128);            // add x7,x0,x0
    #1 chk("lw_x0_no_hazard", hazard_stall, 0);
    tick();
    chk("lw_x0_no_bubble", valid_e, 1);

    // Illegal opcode.
    drive_f(1, 32'h0000_0000, 32'h12C);
    tick();
    chk("illegal_flag", illegal_e, 1);
    chk("illegal_ctrl", ctrl_e, 0);
    chk("illegal_valid", valid_e, 1);

    // valid_f=0 suppresses the hazard and captures a bubble.
    drive_f(1, 32'h0000_A303, 32'h130);
    tick();
    drive_f(0, 32'h0023_03B3, 32'h134);
    #1 chk("invalid_f_no_hazard", hazard_stall, 0);
    tick();
    chk("invalid_f_bubble", valid_e, 0);

    // Immediate and control pins across formats.
    drive_f(1, 32'hFE20_8CE3, 32'h200); tick();    // beq x1,x2,-8
    chk("beq_imm", imm_e, 32'hFFFF_FFF8);
    chk("beq_ctrl", ctrl_e, 16'h0440);
    drive_f(1, 32'h1234_5537, 32'h204); tick();    // lui x10,0x12345
    chk("lui_imm", imm_e, 32'h1234_5000);
    chk("lui_ctrl", ctrl_e, 16'hE028);
    drive_f(1, 32'h0080_00EF, 32'h208); tick();    // jal x1,8
    chk("jal_imm", imm_e, 32'h8);
    chk("jal_ctrl", ctrl_e, 16'hC800);
    drive_f(1, 32'h4030_D293, 32'h20C); tick();    // srai x5,x1,3
    chk("srai_ctrl", ctrl_e, 16'h826A);
    chk("srai_imm", imm_e, 32'h403);
    drive_f(1, 32'h0020_A423, 32'h210); tick();    // sw x2,8(x1)
    chk("sw_ctrl", ctrl_e, 16'h1012);
    chk("sw_imm", imm_e, 32'h8);
    drive_f(1, 32'h4020_82B3, 32'h214); tick();    // sub x5,x1,x2
    chk("sub_ctrl", ctrl_e, 16'h8040);

    // Mixed traffic with small register indices to provoke hazards.
    for (int i = 0; i < 120; i++) begin
      r = $urandom();
      r[6:0]   = ops[$urandom_range(0, 9)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      drive_f($urandom_range(0, 9) != 0, r, AW'($urandom_range(0, 4095)) << 2);
      stall_d = ($urandom_range(0, 5) == 0);
      flush_d = ($urandom_range(0, 9) == 0);
      wb($urandom_range(0, 1) == 1, RAW'($urandom_range(0, 3)), $urandom());
      tick();
    end
    stall_d = 0; flush_d = 0;
    wb(0, 0, 0);

    // Reset during a stalled load-use discards the held instruction.
    drive_f(1, 32'h0000_A303, 32'h300); tick();
    drive_f(1, 32'h0023_03B3, 32'h304);
    stall_d = 1;
    tick();
    rst = 1;
    #1 chk("rst_mid_stall_valid", valid_e, 0);
    tick();
    rst = 0; stall_d = 0;
    drive_f(1, 32'hFFF0_0093, 32'h308);
    #1 chk("rst_release_no_capture", valid_e, 0);
    tick();
    chk("rst_first_capture", valid_e, 1);
    chk("rst_first_capture_ctrl", ctrl_e, 16'h8002);

    drive_f(0, 32'h0, 32'h0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
